// File: rtl/div32.sv
// 32-bit unsigned restoring divider: one quotient bit per clock, MSB first.
// A zero divisor completes on the start edge with an all-ones quotient and the dividend as remainder.
module div32 (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        start,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        finish,
    output logic        busy,
    output logic        div_zero,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [32:0] prem_q;
    logic [31:0] shreg_q;
    logic [31:0] dvs_q;
    logic [5:0]  cnt_q;
    logic [31:0] quot_q;
    logic [31:0] rem_q;
    logic        fin_q;
    logic        busy_q;
    logic        dz_q;

    logic [33:0] shifted;
    logic [33:0] trial;
    logic        qbit;
    logic [32:0] prem_d;
    logic [31:0] shreg_d;

    // The trial difference goes negative exactly when its top bit is set.
    always_comb begin
        shifted = {prem_q, shreg_q[31]};
        trial   = shifted - {2'b00, dvs_q};
        qbit    = ~trial[33];
        prem_d  = qbit ? trial[32:0] : shifted[32:0];
        shreg_d = {shreg_q[30:0], qbit};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            prem_q  <= 33'd0;
            shreg_q <= 32'd0;
            dvs_q   <= 32'd0;
            cnt_q   <= 6'd0;
            quot_q  <= 32'd0;
            rem_q   <= 32'd0;
            fin_q   <= 1'b0;
            busy_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else if (start) begin
            prem_q  <= 33'd0;
            cnt_q   <= 6'd0;
            shreg_q <= dividend;
            dvs_q   <= divisor;
            if (divisor == 32'd0) begin
                state_q <= S_DONE;
                quot_q  <= 32'hFFFF_FFFF;
                rem_q   <= dividend;
                fin_q   <= 1'b1;
                busy_q  <= 1'b0;
                dz_q    <= 1'b1;
            end else begin
                state_q <= S_BUSY;
                fin_q   <= 1'b0;
                busy_q  <= 1'b1;
                dz_q    <= 1'b0;
            end
        end else if (state_q == S_BUSY) begin
            prem_q  <= prem_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_q + 6'd1;
            // Results stay frozen until the 32nd step lands.
            if (cnt_q == 6'd31) begin
                state_q <= S_DONE;
                quot_q  <= shreg_d;
                rem_q   <= prem_d[31:0];
                fin_q   <= 1'b1;
                busy_q  <= 1'b0;
            end
        end
    end

    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign finish    = fin_q;
    assign busy      = busy_q;
    assign div_zero  = dz_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_div32.sv
// Directed bench for div32: fixed vectors, abort, async reset, held start and a small random sweep.
module tb_div32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] dividend = 32'd0;
    logic [31:0] divisor = 32'd0;
    logic        start = 1'b0;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        finish;
    logic        busy;
    logic        div_zero;
    logic [1:0]  dbg_state;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] last_q = 32'd0;
    logic [31:0] last_r = 32'd0;

    div32 dut (
        .clk      (clk),
        .rst      (rst),
        .dividend (dividend),
        .divisor  (divisor),
        .start    (start),
        .quotient (quotient),
        .remainder(remainder),
        .finish   (finish),
        .busy     (busy),
        .div_zero (div_zero),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full operation with a nonzero divisor, checking latency, busy width and output hold.
    task automatic run_div(input string tag, input logic [31:0] dd, input logic [31:0] ds,
                           input logic [31:0] eq, input logic [31:0] er);
        int   cyc;
        int   busy_cnt;
        logic held;
        dividend = dd;
        divisor  = ds;
        start    = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, " busy_after_start"}, {31'd0, busy}, 32'd1);
        chk({tag, " finish_after_start"}, {31'd0, finish}, 32'd0);
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        cyc  = 0;
        held = 1'b1;
        while (finish !== 1'b1 && cyc < 40) begin
            if (quotient !== last_q || remainder !== last_r) held = 1'b0;
            tick();
            cyc++;
            if (busy === 1'b1) busy_cnt++;
        end
        chk({tag, " latency"}, cyc, 32'd32);
        chk({tag, " busy_cycles"}, busy_cnt, 32'd32);
        chk({tag, " outputs_held"}, {31'd0, held}, 32'd1);
        chk({tag, " quotient"}, quotient, eq);
        chk({tag, " remainder"}, remainder, er);
        chk({tag, " div_zero"}, {31'd0, div_zero}, 32'd0);
        chk({tag, " busy_done"}, {31'd0, busy}, 32'd0);
        last_q = eq;
        last_r = er;
        repeat (3) tick();
        chk({tag, " finish_stable"}, {31'd0, finish}, 32'd1);
        chk({tag, " quotient_stable"}, quotient, eq);
    endtask

    task automatic run_zero(input string tag, input logic [31:0] dd);
        dividend = dd;
        divisor  = 32'd0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, " finish"}, {31'd0, finish}, 32'd1);
        chk({tag, " div_zero"}, {31'd0, div_zero}, 32'd1);
        chk({tag, " busy"}, {31'd0, busy}, 32'd0);
        chk({tag, " quotient"}, quotient, 32'hFFFF_FFFF);
        chk({tag, " remainder"}, remainder, dd);
        repeat (4) tick();
        chk({tag, " finish_stable"}, {31'd0, finish}, 32'd1);
        chk({tag, " busy_stays_low"}, {31'd0, busy}, 32'd0);
        last_q = 32'hFFFF_FFFF;
        last_r = dd;
    endtask

    initial begin
        logic        seen;
        int          cyc;
        logic [31:0] dd;
        logic [31:0] ds;
        logic [31:0] specials [4];

        // Reset state, then idle with start low.
        #3;
        chk("reset quotient", quotient, 32'd0);
        chk("reset remainder", remainder, 32'd0);
        chk("reset finish", {31'd0, finish}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset div_zero", {31'd0, div_zero}, 32'd0);
        chk("reset state", {30'd0, dbg_state}, 32'd0);
        tick();
        rst = 1'b1;
        repeat (5) tick();
        chk("idle finish", {31'd0, finish}, 32'd0);
        chk("idle state", {30'd0, dbg_state}, 32'd0);

        run_div("100/7", 32'd100, 32'd7, 32'd14, 32'd2);
        run_div("max/1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
        run_div("5/9", 32'd5, 32'd9, 32'd0, 32'd5);
        run_zero("1234/0", 32'd1234);

        // Abort 100/7 at step 10 with a fresh 50/3.
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        tick();
        start = 1'b0;
        seen  = 1'b0;
        repeat (10) begin
            tick();
            if (finish === 1'b1) seen = 1'b1;
        end
        chk("abort no_early_finish", {31'd0, seen}, 32'd0);
        chk("abort state_busy", {30'd0, dbg_state}, 32'd1);
        run_div("abort 50/3", 32'd50, 32'd3, 32'd16, 32'd2);

        // Asynchronous reset at step 16, between clock edges.
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (16) tick();
        #1;
        rst = 1'b0;
        #1;
        chk("async_rst quotient", quotient, 32'd0);
        chk("async_rst remainder", remainder, 32'd0);
        chk("async_rst busy", {31'd0, busy}, 32'd0);
        chk("async_rst finish", {31'd0, finish}, 32'd0);
        chk("async_rst div_zero", {31'd0, div_zero}, 32'd0);
        tick();
        rst  = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (finish === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        chk("post_rst stays_idle", {31'd0, seen}, 32'd0);
        last_q = 32'd0;
        last_r = 32'd0;

        // Start held high: reloads every edge, never finishes.
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        seen     = 1'b0;
        repeat (40) begin
            tick();
            if (finish === 1'b1) seen = 1'b1;
        end
        chk("held_start no_finish", {31'd0, seen}, 32'd0);
        chk("held_start busy", {31'd0, busy}, 32'd1);
        start = 1'b0;
        cyc   = 0;
        while (finish !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("held_start latency", cyc, 32'd32);
        chk("held_start quotient", quotient, 32'd14);
        chk("held_start remainder", remainder, 32'd2);
        last_q = 32'd14;
        last_r = 32'd2;

        run_div("max/max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0);
        run_div("0/5", 32'd0, 32'd5, 32'd0, 32'd0);
        run_div("12345678/1000", 32'd12345678, 32'd1000, 32'd12345, 32'd678);
        run_div("2^31/3", 32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 32'd2);
        run_zero("max/0", 32'hFFFF_FFFF);

        // Random pairs mixed with boundary values.
        specials[0] = 32'd0;
        specials[1] = 32'd1;
        specials[2] = 32'hFFFF_FFFF;
        specials[3] = 32'h8000_0000;
        for (int i = 0; i < 150; i++) begin
            dd = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
            ds = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
            if ($urandom_range(0, 2) == 0) ds = ds >> $urandom_range(1, 31);
            if (ds == 32'd0) run_zero("rand zero", dd);
            else run_div("rand", dd, ds, dd / ds, dd % ds);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/div32.md
DIV32 -- requirements
Module: div32

Interface
REQ-001 Parameters: none; operand and result widths SHALL be fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; rst=0 SHALL force reset state immediately, independent of clk.
REQ-004 dividend  input  32  unsigned dividend, sampled only on a rising edge where start=1.
REQ-005 divisor  input  32  unsigned divisor, sampled only on a rising edge where start=1.
REQ-006 start  input  1  level-sampled request; start=1 on a rising edge SHALL load a new operation.
REQ-007 quotient  output  32  registered unsigned quotient.
REQ-008 remainder  output  32  registered unsigned remainder.
REQ-009 finish  output  1  registered; 1 = result valid and unit idle.
REQ-010 busy  output  1  registered; 1 = iteration in progress.
REQ-011 div_zero  output  1  registered; 1 = last completed operation had divisor=0.

Function
REQ-012 Algorithm: unsigned restoring shift-subtract, one quotient bit per cycle, MSB first.
REQ-013 FSM states:
- IDLE: no valid result since reset.
- BUSY: iterating.
- DONE: result valid.
REQ-014 Step datapath: 33-bit partial remainder, 32-bit dividend/quotient shift register, 6-bit step counter, latched divisor copy.
REQ-015 Any state, start=1 on an edge with divisor!=0: latch operands; clear partial remainder and counter; go to BUSY; busy=1, finish=0, div_zero=0.
REQ-016 Start during BUSY SHALL abort the current operation and restart with the newly sampled operands.
REQ-017 Start in DONE SHALL begin a new operation; finish drops on that same edge.
REQ-018 Each BUSY edge with start=0 SHALL perform exactly one step:
- Shift {partial remainder, dividend MSB} left by one.
- Trial-subtract the divisor.
- Non-negative result: keep it and shift quotient bit 1 in.
- Negative result: restore and shift quotient bit 0 in.
REQ-019 After the 32nd step edge: quotient/remainder outputs load the final values; busy=0, finish=1; go to DONE.
REQ-020 Latency: start sampled at edge E0 → finish=1 after edge E32 (32 cycles).
REQ-021 quotient/remainder outputs SHALL hold the previous result throughout BUSY and change only at completion.
REQ-022 divisor=0 sampled with start=1 SHALL skip iteration and go directly to DONE on that edge:
- finish=1, div_zero=1, busy=0.
- quotient=32'hFFFFFFFF, remainder=dividend.
REQ-023 finish and the results SHALL remain stable in DONE indefinitely until start=1 or reset.
REQ-024 start held high continuously SHALL reload on every edge; finish SHALL never assert, except in the divisor=0 case.
REQ-025 Results SHALL satisfy dividend = quotient*divisor + remainder, with remainder < divisor, for every divisor!=0.
REQ-026 The operation counter SHALL never wrap past 32; no step SHALL execute in IDLE or DONE.

Reset
REQ-027 rst=0 SHALL asynchronously set: state=IDLE, quotient=0, remainder=0, finish=0, busy=0, div_zero=0, counter=0, all internal datapath registers=0.
REQ-028 Reset asserted mid-BUSY SHALL abandon the operation; no partial result SHALL appear on the outputs.
REQ-029 After rst deasserts, the unit SHALL stay in IDLE until the first edge with start=1.

Verification
REQ-030 dividend=100, divisor=7, one-cycle start → after 32 edges: finish=1, quotient=14, remainder=2, div_zero=0; busy=1 for exactly 32 cycles.
REQ-031 dividend=32'hFFFFFFFF, divisor=1 → quotient=32'hFFFFFFFF, remainder=0; dividend=5, divisor=9 → quotient=0, remainder=5.
REQ-032 dividend=1234, divisor=0 → next edge: finish=1, div_zero=1, quotient=32'hFFFFFFFF, remainder=1234, busy never 1.
REQ-033 Start 100/7, then at step 10 start 50/3 → finish 32 cycles after the second start with quotient=16, remainder=2; 100/7 result never appears.
REQ-034 rst=0 pulsed at step 16 of 100/7 → all outputs 0 immediately (no clk edge needed); no finish until a new start.
REQ-035 Random regression, 10k unsigned pairs including 0, 1 and 32'hFFFFFFFF → REQ-025 holds and latency is exactly 32 for every nonzero divisor.
